// File: rtl/cic_pkg.sv
// Shared types and sizing helpers for the CIC interpolator.
package cic_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cic_state_e;

    typedef struct packed {
        int unsigned acc_width;
        int unsigned out_shift;
    } cic_dims_t;

    // Ceiling log2 for elaboration-time sizing.
    function automatic int unsigned cic_log2(int unsigned value);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) n = i + 1;
        end
        return n;
    endfunction

    // Accumulator width and output shift giving unity DC gain.
    function automatic cic_dims_t cic_dims(int unsigned data_width,
                                           int unsigned rate,
                                           int unsigned stages);
        cic_dims_t   d;
        int unsigned lg;
        lg          = cic_log2(rate);
        d.acc_width = data_width + stages * lg;
        d.out_shift = (stages - 1) * lg;
        return d;
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One low-rate comb stage: y = x - x_prev, history advanced only when enabled.
module cic_comb_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y_c
);

    logic signed [WIDTH-1:0] x_prev;

    // Differential-delay register, updated once per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev <= '0;
        end else if (en) begin
            x_prev <= x;
        end
    end

    assign y_c = x - x_prev;

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: low-rate combs, zero-stuffer, high-rate integrators.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RATE       = 8,
    parameter int unsigned STAGES     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] data_out,
    output logic                         out_valid,
    output logic                         underrun
);

    localparam cic_dims_t   DIMS        = cic_dims(DATA_WIDTH, RATE, STAGES);
    localparam int unsigned ACC_WIDTH   = DIMS.acc_width;
    localparam int unsigned OUT_SHIFT   = DIMS.out_shift;
    localparam int unsigned PHASE_WIDTH = $clog2(RATE);
    localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(RATE - 1);

    cic_state_e                state_q, state_d;
    logic [PHASE_WIDTH-1:0]    phase_q, phase_d;
    logic                      in_ready_d;
    logic                      underrun_d;
    logic                      accept_c;

    logic signed [ACC_WIDTH-1:0] data_ext;
    logic signed [ACC_WIDTH-1:0] comb_out_c;
    logic signed [ACC_WIDTH-1:0] comb_q;
    logic signed [ACC_WIDTH-1:0] stuff_c;
    logic signed [ACC_WIDTH-1:0] shifted_c;
    logic                        out_unused;
    logic [STAGES:0]             run_pipe;

    assign accept_c = in_valid && in_ready;

    // Next state: one input per RATE cycles, drop to IDLE on a missing frame sample.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_RUN;
                    phase_d = '0;
                end
            end
            ST_RUN: begin
                if (phase_q == LAST_PHASE) begin
                    phase_d = '0;
                    if (!accept_c) begin
                        state_d    = ST_IDLE;
                        underrun_d = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PHASE_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE) || (phase_d == LAST_PHASE);
    end

    // FSM state plus its registered handshake/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            in_ready <= 1'b1;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            in_ready <= in_ready_d;
            underrun <= underrun_d;
        end
    end

    // RUN indication delayed per stage; bit k enables integrator k, last bit is out_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_pipe <= '0;
        end else begin
            run_pipe <= {run_pipe[STAGES-1:0], state_d == ST_RUN};
        end
    end

    assign out_valid = run_pipe[STAGES];

    assign data_ext = {{(ACC_WIDTH - DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};

    // Comb cascade, advanced only on acceptance.
    for (genvar g = 0; g < STAGES; g++) begin : g_comb
        logic signed [ACC_WIDTH-1:0] x;
        logic signed [ACC_WIDTH-1:0] y;
        if (g == 0) begin : g_first
            assign x = data_ext;
        end else begin : g_rest
            assign x = g_comb[g-1].y;
        end
        cic_comb_stage #(
            .WIDTH(ACC_WIDTH)
        ) u_comb (
            .clk  (clk),
            .rst_n(reset),
            .en   (accept_c),
            .x    (x),
            .y_c  (y)
        );
    end

    assign comb_out_c = g_comb[STAGES-1].y;

    // Comb output register feeding the zero-stuffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            comb_q <= '0;
        end else if (accept_c) begin
            comb_q <= comb_out_c;
        end
    end

    assign stuff_c = (phase_q == '0) ? comb_q : '0;

    // Integrator cascade; each stage runs while its delayed RUN bit is set so a frozen pipeline drains cleanly.
    for (genvar g = 0; g < STAGES; g++) begin : g_integ
        logic signed [ACC_WIDTH-1:0] din;
        logic signed [ACC_WIDTH-1:0] acc;
        if (g == 0) begin : g_first
            assign din = stuff_c;
        end else begin : g_rest
            assign din = g_integ[g-1].acc;
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                acc <= '0;
            end else if (run_pipe[g]) begin
                acc <= acc + din;
            end
        end
    end

    assign shifted_c  = g_integ[STAGES-1].acc >>> OUT_SHIFT;
    assign data_out   = shifted_c[DATA_WIDTH-1:0];
    assign out_unused = ^shifted_c[ACC_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench for cic_interpolator at default parameters (16 bit, R=8, N=3).
module tb_cic_interpolator;

    localparam int R     = 8;
    localparam int H_LEN = 22;
    localparam int SHIFT = 6;

    logic               clk;
    logic               reset;
    logic signed [15:0] data_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] data_out;
    logic               out_valid;
    logic               underrun;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     burst_start = 0;
    int     under_cyc   = 0;
    logic   ov_prev = 1'b0;
    longint exp_v;
    longint last_out = 0;
    longint hist[$];
    longint exp_q[$];
    int     h_coef[H_LEN] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                              48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

    cic_interpolator #(
        .DATA_WIDTH(16),
        .RATE      (8),
        .STAGES    (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .out_valid(out_valid),
        .underrun (underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: zero-stuffed input convolved with the CIC impulse response, /64, 16-bit wrap.
    task automatic model_accept(input longint v);
        longint             acc;
        int                 k;
        int                 idx;
        logic signed [15:0] t;
        hist.push_back(v);
        k = hist.size() - 1;
        for (int p = 0; p < R; p++) begin
            acc = 0;
            for (int j = 0; j <= k; j++) begin
                idx = (k - j) * R + p;
                if (idx < H_LEN) acc += hist[j] * h_coef[idx];
            end
            t = 16'(acc >>> SHIFT);
            exp_q.push_back(t);
        end
    endtask

    // Output monitor: scoreboard pops plus latency/fall timing.
    always @(negedge clk) begin
        if (!reset) begin
            ov_prev = 1'b0;
        end else begin
            if (out_valid && !ov_prev) check_eq("latency", cyc - burst_start, 4);
            if (!out_valid && ov_prev) check_eq("valid_fall", cyc - under_cyc, 4);
            if (out_valid) begin
                check_eq("exp_avail", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_v = exp_q.pop_front();
                    check_eq("data_out", data_out, exp_v);
                    last_out = data_out;
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic apply_reset();
        in_valid = 1'b0;
        data_in  = '0;
        reset    = 1'b0;
        #1;
        hist.delete();
        exp_q.delete();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Streams n frames from IDLE; returns inside the phase-7 cycle of the last frame.
    task automatic send_frames(input int n, input longint first, input longint rest, input bit rnd);
        longint v;
        for (int i = 0; i < n; i++) begin
            if (rnd) v = longint'($signed(16'($urandom_range(0, 65535))));
            else     v = (i == 0) ? first : rest;
            in_valid = 1'b1;
            data_in  = 16'(v);
            @(negedge clk);
            check_eq("ready_accept", in_ready, 1);
            if (i == 0) burst_start = cyc;
            @(posedge clk);
            #1;
            model_accept(v);
            for (int j = 1; j < R; j++) begin
                @(negedge clk);
                check_eq("ready_busy", in_ready, 0);
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic underrun_check();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("ur_ready_p7", in_ready, 1);
        check_eq("ur_before", underrun, 0);
        under_cyc = cyc;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("ur_pulse", underrun, 1);
        check_eq("ur_ready_idle", in_ready, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("ur_after", underrun, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
        check_eq("drained", exp_q.size(), 0);
        check_eq("idle_valid", out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        #2;
        apply_reset();

        // Impulse response.
        send_frames(5, 64, 0, 1'b0);
        underrun_check();
        drain();

        // Single sample from reset, underrun, then resume with zeros.
        apply_reset();
        send_frames(1, 64, 0, 1'b0);
        underrun_check();
        drain();
        send_frames(4, 0, 0, 1'b0);
        underrun_check();
        drain();

        // Step.
        apply_reset();
        send_frames(5, 1000, 1000, 1'b0);
        underrun_check();
        drain();
        check_eq("step_final", last_out, 1000);

        // Full scale negative and positive.
        apply_reset();
        send_frames(5, -32768, -32768, 1'b0);
        underrun_check();
        drain();
        check_eq("fs_neg_final", last_out, -32768);
        apply_reset();
        send_frames(5, 32767, 32767, 1'b0);
        underrun_check();
        drain();
        check_eq("fs_pos_final", last_out, 32767);

        // Underrun after 3 samples, resume with the same constant.
        apply_reset();
        send_frames(3, 500, 500, 1'b0);
        underrun_check();
        drain();
        send_frames(4, 500, 500, 1'b0);
        underrun_check();
        drain();
        check_eq("resume_final", last_out, 500);

        // Random samples, exercising output wrap.
        apply_reset();
        send_frames(6, 0, 0, 1'b1);
        underrun_check();
        drain();

        // Reset asserted at phase 3 of a run.
        apply_reset();
        in_valid = 1'b1;
        data_in  = 16'sd64;
        @(negedge clk);
        check_eq("mr_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mr_pre_valid", out_valid, 1);
        check_eq("mr_pre_data", data_out, 1);
        reset = 1'b0;
        #1;
        hist.delete();
        exp_q.delete();
        check_eq("mr_data_out", data_out, 0);
        check_eq("mr_out_valid", out_valid, 0);
        check_eq("mr_in_ready", in_ready, 1);
        check_eq("mr_underrun", underrun, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mr_post_valid", out_valid, 0);
        @(posedge clk);
        #1;
        send_frames(4, 64, 0, 1'b0);
        underrun_check();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
